icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache; the responder on the fetch-side cache bus (p_*).

---
 rtl/icache_dm.sv | 131 +++++++++++++
 tb/tb_icache_dm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with whole-line refill
module icache_dm #(
   parameter int ADDR_W   = 25,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_p_addr,
   input  logic [3:0]        i_p_byte_en,
   input  logic [31:0]       i_p_writedata,
   input  logic              i_p_read,
   input  logic              i_p_write,
   output logic [31:0]       o_p_readdata,
   output logic              o_p_readdata_valid,
   output logic              o_p_waitrequest,
   input  logic              i_flush,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_read,
   input  logic [31:0]       m_readdata,
   input  logic              m_readdata_valid,
   input  logic              m_waitrequest
);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES  = 1 << INDEX_W;
   localparam int WORDS  = 1 << OFFSET_W;
   localparam int LINE_W = ADDR_W - OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST_CNT = '1;

   typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESP} state_t;
   state_t state, state_nx;

   logic [31:0]         data_mem [LINES*WORDS];
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [LINES-1:0]    valid;
   logic [LINE_W-1:0]   line_addr;
   logic [OFFSET_W-1:0] cnt;
   logic [OFFSET_W-1:0] req_off;
   logic                flushed;

   logic [TAG_W-1:0]    p_tag;
   logic [INDEX_W-1:0]  p_index;
   logic [OFFSET_W-1:0] p_offset;
   logic [INDEX_W-1:0]  line_index;
   logic [TAG_W-1:0]    line_tag;
   logic                hit;
   logic                unused_p;

   assign p_tag      = i_p_addr[ADDR_W-1 -: TAG_W];
   assign p_index    = i_p_addr[OFFSET_W +: INDEX_W];
   assign p_offset   = i_p_addr[OFFSET_W-1:0];
   assign line_index = line_addr[INDEX_W-1:0];
   assign line_tag   = line_addr[LINE_W-1 -: TAG_W];
   assign m_addr     = {line_addr, cnt};
   assign unused_p   = ^{i_p_byte_en, i_p_writedata, i_p_write};

   // A flush in the lookup cycle forces a miss even if the line looked valid.
   assign hit = valid[p_index] && (tag_mem[p_index] == p_tag) && !i_flush;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      m_read   = 1'b0;
      case (state)
         IDLE:      if (i_p_read && !hit) state_nx = FILL_REQ;
         FILL_REQ: begin
            m_read = 1'b1;
            if (!m_waitrequest) state_nx = FILL_WAIT;
         end
         FILL_WAIT: if (m_readdata_valid) state_nx = (cnt == LAST_CNT) ? RESP : FILL_REQ;
         RESP:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_p_readdata       <= '0;
         o_p_readdata_valid <= 1'b0;
         o_p_waitrequest    <= 1'b0;
         line_addr          <= '0;
         cnt                <= '0;
         req_off            <= '0;
         flushed            <= 1'b0;
      end else begin
         o_p_readdata       <= '0;
         o_p_readdata_valid <= 1'b0;
         case (state)
            IDLE: if (i_p_read) begin
               if (hit) begin
                  o_p_readdata_valid <= 1'b1;
                  o_p_readdata       <= data_mem[{p_index, p_offset}];
               end else begin
                  o_p_waitrequest <= 1'b1;
                  line_addr       <= i_p_addr[ADDR_W-1:OFFSET_W];
                  req_off         <= p_offset;
                  cnt             <= '0;
                  flushed         <= 1'b0;
               end
            end
            FILL_WAIT: if (m_readdata_valid && cnt != LAST_CNT) cnt <= cnt + 1'b1;
            RESP: begin
               o_p_readdata_valid <= 1'b1;
               o_p_readdata       <= data_mem[{line_index, req_off}];
               o_p_waitrequest    <= 1'b0;
            end
            default: ;
         endcase
         // Any flush seen while a fill is in flight keeps the refilled line invalid.
         if (state != IDLE && i_flush) flushed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else begin
         if (i_flush) valid <= '0;
         if (state == RESP && !flushed && !i_flush) valid[line_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == FILL_WAIT && m_readdata_valid) data_mem[{line_index, cnt}] <= m_readdata;
      if (!rst && state == RESP) tag_mem[line_index] <= line_tag;
   end
endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm
module tb_icache_dm;
   logic        clk, rst;
   logic [24:0] i_p_addr;
   logic [3:0]  i_p_byte_en;
   logic [31:0] i_p_writedata;
   logic        i_p_read, i_p_write, i_flush;
   logic [31:0] o_p_readdata;
   logic        o_p_readdata_valid, o_p_waitrequest;
   logic [24:0] m_addr;
   logic        m_read;
   logic [31:0] m_readdata;
   logic        m_readdata_valid, m_waitrequest;

   int checks = 0;
   int failures = 0;
   logic stall_force, rand_stall, mem_inject;
   logic [24:0] maddr_q[$];
   bit          mv[64];
   logic [16:0] mt[64];

   typedef struct {
      logic [24:0] addr;
      int          flush_at;
      logic        exp_miss;
   } vec_t;
   vec_t vecs[14];

   icache_dm dut (
      .clk(clk), .rst(rst),
      .i_p_addr(i_p_addr), .i_p_byte_en(i_p_byte_en), .i_p_writedata(i_p_writedata),
      .i_p_read(i_p_read), .i_p_write(i_p_write),
      .o_p_readdata(o_p_readdata), .o_p_readdata_valid(o_p_readdata_valid),
      .o_p_waitrequest(o_p_waitrequest), .i_flush(i_flush),
      .m_addr(m_addr), .m_read(m_read), .m_readdata(m_readdata),
      .m_readdata_valid(m_readdata_valid), .m_waitrequest(m_waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [24:0] a);
      return {7'h5A, a} ^ {a[15:0], 16'h3C1D};
   endfunction

   // Memory: accepts when m_read && !m_waitrequest, returns the word one cycle later.
   initial begin
      logic        fire;
      logic [24:0] faddr;
      m_readdata = '0;
      m_readdata_valid = 1'b0;
      m_waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         fire  = m_read && !m_waitrequest;
         faddr = m_addr;
         if (fire) maddr_q.push_back(faddr);
         @(posedge clk);
         #1;
         m_readdata_valid = fire || mem_inject;
         m_readdata       = fire ? mem_word(faddr) : $urandom;
         m_waitrequest    = stall_force || (rand_stall && $urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_line(input logic [24:0] addr);
      logic [24:0] base, a;
      base = addr & ~25'h3;
      chk("mread_count", maddr_q.size(), 4);
      for (int w = 0; w < 4 && maddr_q.size() > 0; w++) begin
         a = maddr_q.pop_front();
         chk("mread_addr", a, base + 25'(w));
      end
      maddr_q.delete();
   endtask

   task automatic wait_resp(input int flush_at, output logic [31:0] data, output int lat);
      int k = 1;
      while (o_p_waitrequest && !o_p_readdata_valid && k < 300) begin
         i_flush       = (k == flush_at);
         i_p_read      = 1'($urandom_range(0, 1));
         i_p_addr      = 25'($urandom);
         i_p_write     = 1'($urandom_range(0, 1));
         i_p_writedata = $urandom;
         i_p_byte_en   = 4'($urandom);
         step();
         k++;
      end
      i_p_read  = 1'b0;
      i_p_write = 1'b0;
      i_flush   = 1'b0;
      chk("resp_valid", o_p_readdata_valid, 1);
      chk("resp_waitrequest", o_p_waitrequest, 0);
      data = o_p_readdata;
      lat  = k;
   endtask

   task automatic fetch_check(input logic [24:0] addr, input int flush_at, input logic exp_miss,
                              input int exp_lat);
      logic [31:0] data;
      int lat;
      i_p_addr  = addr;
      i_p_read  = 1'b1;
      i_p_write = 1'b0;
      i_flush   = 1'b0;
      step();
      i_p_read = 1'b0;
      chk("miss", o_p_waitrequest, exp_miss);
      if (o_p_waitrequest) begin
         chk("miss_valid_low", o_p_readdata_valid, 0);
         wait_resp(flush_at, data, lat);
         if (exp_lat > 0) chk("latency", lat, exp_lat);
      end else begin
         chk("hit_valid", o_p_readdata_valid, 1);
         data = o_p_readdata;
      end
      chk("data", data, mem_word(addr));
      if (exp_miss) check_line(addr);
      else chk("hit_no_mread", maddr_q.size(), 0);
   endtask

   initial begin
      vecs[0]  = '{25'h0000010, -1, 1'b1};
      vecs[1]  = '{25'h0000013, -1, 1'b0};
      vecs[2]  = '{25'h0000410, -1, 1'b1};
      vecs[3]  = '{25'h0000012, -1, 1'b1};
      vecs[4]  = '{25'h0000411, -1, 1'b1};
      vecs[5]  = '{25'h0000020, -1, 1'b1};
      vecs[6]  = '{25'h0000023, -1, 1'b0};
      vecs[7]  = '{25'h1FFFFFF, -1, 1'b1};
      vecs[8]  = '{25'h1FFFFFC, -1, 1'b0};
      vecs[9]  = '{25'h0000000, -1, 1'b1};
      vecs[10] = '{25'h0000030,  4, 1'b1};
      vecs[11] = '{25'h0000030, -1, 1'b1};
      vecs[12] = '{25'h0000020, -1, 1'b1};
      vecs[13] = '{25'h0000010, -1, 1'b1};

      rst = 1'b1; i_p_addr = '0; i_p_byte_en = '0; i_p_writedata = '0;
      i_p_read = 1'b0; i_p_write = 1'b0; i_flush = 1'b0;
      stall_force = 1'b0; rand_stall = 1'b0; mem_inject = 1'b0;
      repeat (3) step();
      chk("reset_waitrequest", o_p_waitrequest, 0);
      chk("reset_valid", o_p_readdata_valid, 0);
      chk("reset_readdata", o_p_readdata, 0);
      chk("reset_m_read", m_read, 0);
      chk("reset_m_addr", m_addr, 0);
      rst = 1'b0;
      step();

      foreach (vecs[i]) fetch_check(vecs[i].addr, vecs[i].flush_at, vecs[i].exp_miss,
                                    vecs[i].exp_miss ? 10 : 0);

      // Back-to-back hits on the freshly loaded line.
      for (int w = 1; w <= 3; w++) begin
         i_p_addr = 25'h10 + 25'(w);
         i_p_read = 1'b1;
         step();
         chk("b2b_valid", o_p_readdata_valid, 1);
         chk("b2b_data", o_p_readdata, mem_word(25'h10 + 25'(w)));
         chk("b2b_waitrequest", o_p_waitrequest, 0);
         chk("b2b_m_read", m_read, 0);
      end
      i_p_read = 1'b0;
      step();
      chk("b2b_idle_valid", o_p_readdata_valid, 0);

      // Memory stalls the first refill request for several cycles.
      begin
         logic [31:0] data;
         int lat;
         stall_force = 1'b1;
         i_p_addr = 25'h70;
         i_p_read = 1'b1;
         step();
         i_p_read = 1'b0;
         chk("stall_miss", o_p_waitrequest, 1);
         for (int s = 0; s < 5; s++) begin
            chk("stall_m_read", m_read, 1);
            chk("stall_m_addr", m_addr, 25'h70);
            step();
         end
         stall_force = 1'b0;
         wait_resp(-1, data, lat);
         chk("stall_data", data, mem_word(25'h70));
         check_line(25'h70);
      end

      // Reset in the middle of a fill, followed by a stray memory response.
      i_p_addr = 25'h50;
      i_p_read = 1'b1;
      step();
      i_p_read = 1'b0;
      chk("rst_miss", o_p_waitrequest, 1);
      step();
      chk("rst_fill_wait_m_read", m_read, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_waitrequest", o_p_waitrequest, 0);
      chk("rst_mid_valid", o_p_readdata_valid, 0);
      chk("rst_mid_readdata", o_p_readdata, 0);
      chk("rst_mid_m_read", m_read, 0);
      chk("rst_mid_m_addr", m_addr, 0);
      mem_inject = 1'b1;
      step();
      mem_inject = 1'b0;
      step();
      chk("stray_waitrequest", o_p_waitrequest, 0);
      chk("stray_valid", o_p_readdata_valid, 0);
      chk("stray_m_read", m_read, 0);
      chk("stray_m_addr", m_addr, 0);
      maddr_q.delete();
      fetch_check(25'h10, -1, 1'b1, 10);

      // Random fetches against a line-level model of the cache contents.
      foreach (mv[i]) mv[i] = 1'b0;
      mv[4] = 1'b1;
      mt[4] = 17'h0;
      rand_stall = 1'b1;
      for (int n = 0; n < 120; n++) begin
         logic [24:0] addr;
         logic [16:0] tag;
         int idx, fa, gap;
         logic em;
         gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) begin
            i_p_read      = 1'b0;
            i_p_write     = 1'($urandom_range(0, 1));
            i_p_writedata = $urandom;
            i_flush       = (j == 0) && ($urandom_range(0, 9) == 0);
            if (i_flush) foreach (mv[i]) mv[i] = 1'b0;
            step();
         end
         i_flush   = 1'b0;
         i_p_write = 1'b0;
         idx  = ($urandom_range(0, 4) == 4) ? 63 : $urandom_range(0, 3);
         addr = (25'($urandom_range(0, 2)) << 8) | (25'(idx) << 2) | 25'($urandom_range(0, 3));
         tag  = addr[24:8];
         em   = !(mv[idx] && mt[idx] == tag);
         fa   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : -1;
         fetch_check(addr, fa, em, 0);
         if (em) begin
            if (fa > 0) foreach (mv[i]) mv[i] = 1'b0;
            else begin
               mv[idx] = 1'b1;
               mt[idx] = tag;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
